// File: rtl/ats21_pkg.sv
// Shared types for the ATS21 command scheduler: opcodes, FSM states, bus widths.
// Latency: none (declarations only).
// Backpressure: n/a.
package ats21_pkg;

    // Width of one ATS21 instruction half driven on ctrlA/ctrlB
    localparam int HALF_W = 16;
    // Full client instruction width (two halves)
    localparam int INST_W = 2 * HALF_W;

    // Opcode field, instruction bits [31:29]; 3'b100 is unassigned
    typedef enum logic [2:0] {
        NOP     = 3'b000,
        SET_CLK = 3'b001,
        EN_CLK  = 3'b010,
        MODE    = 3'b011,
        SET_ALM = 3'b101,
        SET_TMR = 3'b110,
        EN_ALM  = 3'b111
    } opcode_e;

    // Scheduler sequence: latch, strobe, wait ready, two halves, wait status, respond
    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        REQ       = 3'd1,
        WAIT_RDY  = 3'd2,
        HI        = 3'd3,
        LO        = 3'd4,
        WAIT_STAT = 3'd5,
        RESP      = 3'd6
    } state_e;

    // True for the clock-programming group, which shares the [28:25] clock index
    function automatic logic is_clk_op(input logic [2:0] op);
        return (op == SET_CLK) || (op == EN_CLK);
    endfunction

    // True for the alarm/timer group, which shares the [28:24] alarm index
    function automatic logic is_alm_op(input logic [2:0] op);
        return (op == SET_ALM) || (op == SET_TMR) || (op == EN_ALM);
    endfunction

endpackage

// File: rtl/ats21_conflict_chk.sv
// Flags two instructions that target the same ATS21 resource and cannot share a slot.
// Latency: combinational.
// Backpressure: none; callers pass NOP (all zeros) for an absent client so it never conflicts.
module ats21_conflict_chk
    import ats21_pkg::*;
(
    input  logic [INST_W-1:0] inst_a,
    input  logic [INST_W-1:0] inst_b,
    output logic              conflict
);

    logic [2:0] op_a;
    logic [2:0] op_b;
    logic       clk_hit;
    logic       alm_hit;
    logic       mode_hit;

    // Same clock index, same alarm index, or two mode writes collide
    always_comb begin
        op_a     = inst_a[31:29];
        op_b     = inst_b[31:29];
        clk_hit  = is_clk_op(op_a) && is_clk_op(op_b) && (inst_a[28:25] == inst_b[28:25]);
        alm_hit  = is_alm_op(op_a) && is_alm_op(op_b) && (inst_a[28:24] == inst_b[28:24]);
        mode_hit = (op_a == MODE) && (op_b == MODE);
        conflict = clk_hit || alm_hit || mode_hit;
    end

endmodule

// File: rtl/ats21_cmd_sched.sv
// Merges two client instructions into one ATS21 transaction (req, hi/lo halves, status).
// Latency: latch + 1 + ready wait + 2 + STAT_DELAY + 1 cycles from IDLE to done.
// Backpressure: clients hold valid until done; a deferred client simply stays pending.
module ats21_cmd_sched
    import ats21_pkg::*;
#(
    parameter int STAT_DELAY  = 2,
    parameter int RDY_TIMEOUT = 15
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              a_valid,
    input  logic [INST_W-1:0] a_inst,
    input  logic              b_valid,
    input  logic [INST_W-1:0] b_inst,
    output logic              a_done,
    output logic              b_done,
    output logic              a_ack,
    output logic              b_ack,
    output logic              busy,
    output logic              req,
    output logic [HALF_W-1:0] ctrlA,
    output logic [HALF_W-1:0] ctrlB,
    input  logic              ready,
    input  logic [1:0]        stat
);

    localparam int TO_W = $clog2(RDY_TIMEOUT + 1);
    localparam int SD_W = (STAT_DELAY < 1) ? 1 : $clog2(STAT_DELAY + 1);
    // Last count value before the wait ends; a zero setting behaves as one cycle
    localparam logic [TO_W-1:0] TO_LAST = TO_W'((RDY_TIMEOUT > 0) ? RDY_TIMEOUT - 1 : 0);
    localparam logic [SD_W-1:0] SD_LAST = SD_W'((STAT_DELAY > 0) ? STAT_DELAY - 1 : 0);

    state_e            state;
    state_e            state_nxt;
    logic [INST_W-1:0] lat_a;
    logic [INST_W-1:0] lat_b;
    logic              iss_a;
    logic              iss_b;
    logic              prio_b;
    logic [TO_W-1:0]   to_cnt;
    logic [SD_W-1:0]   sd_cnt;
    logic              ack_a_q;
    logic              ack_b_q;
    logic [INST_W-1:0] eff_a;
    logic [INST_W-1:0] eff_b;
    logic              conflict;
    logic              sel_a;
    logic              sel_b;
    logic              to_expire;
    logic              sd_expire;

    // An absent client presents NOP so it can never cause a conflict
    always_comb begin
        eff_a = a_valid ? a_inst : '0;
        eff_b = b_valid ? b_inst : '0;
    end

    ats21_conflict_chk u_conflict_chk (
        .inst_a   (eff_a),
        .inst_b   (eff_b),
        .conflict (conflict)
    );

    // Pick which pending clients go out this transaction; the pointer breaks ties
    always_comb begin
        sel_a     = a_valid && (!conflict || !prio_b);
        sel_b     = b_valid && (!conflict ||  prio_b);
        to_expire = (to_cnt >= TO_LAST);
        sd_expire = (sd_cnt >= SD_LAST);
    end

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state decode and Moore outputs; everything idles at zero outside its state
    always_comb begin
        state_nxt = state;
        req       = 1'b0;
        ctrlA     = '0;
        ctrlB     = '0;
        a_done    = 1'b0;
        b_done    = 1'b0;
        a_ack     = 1'b0;
        b_ack     = 1'b0;
        busy      = (state != IDLE);
        case (state)
            IDLE: begin
                if (a_valid || b_valid) begin
                    state_nxt = REQ;
                end
            end
            REQ: begin
                req       = 1'b1;
                state_nxt = WAIT_RDY;
            end
            WAIT_RDY: begin
                if (ready) begin
                    state_nxt = HI;
                end else if (to_expire) begin
                    state_nxt = RESP;
                end
            end
            HI: begin
                ctrlA     = lat_a[INST_W-1:HALF_W];
                ctrlB     = lat_b[INST_W-1:HALF_W];
                state_nxt = LO;
            end
            LO: begin
                ctrlA     = lat_a[HALF_W-1:0];
                ctrlB     = lat_b[HALF_W-1:0];
                state_nxt = WAIT_STAT;
            end
            WAIT_STAT: begin
                if (sd_expire) begin
                    state_nxt = RESP;
                end
            end
            RESP: begin
                a_done    = iss_a;
                b_done    = iss_b;
                a_ack     = iss_a && ack_a_q;
                b_ack     = iss_b && ack_b_q;
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Transaction datapath: latched slots, issue flags, priority, wait counters, acks
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            lat_a   <= '0;
            lat_b   <= '0;
            iss_a   <= 1'b0;
            iss_b   <= 1'b0;
            prio_b  <= 1'b0;
            to_cnt  <= '0;
            sd_cnt  <= '0;
            ack_a_q <= 1'b0;
            ack_b_q <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (a_valid || b_valid) begin
                        lat_a   <= sel_a ? a_inst : '0;
                        lat_b   <= sel_b ? b_inst : '0;
                        iss_a   <= sel_a;
                        iss_b   <= sel_b;
                        // Acks start cleared so a ready timeout reports Nack
                        ack_a_q <= 1'b0;
                        ack_b_q <= 1'b0;
                        if (conflict) begin
                            prio_b <= !prio_b;
                        end
                    end
                end
                REQ: begin
                    to_cnt <= '0;
                end
                WAIT_RDY: begin
                    if (!ready && !to_expire) begin
                        to_cnt <= to_cnt + TO_W'(1);
                    end
                end
                LO: begin
                    sd_cnt <= '0;
                end
                WAIT_STAT: begin
                    if (sd_expire) begin
                        ack_a_q <= stat[0];
                        ack_b_q <= stat[1];
                    end else if (sd_cnt != '1) begin
                        sd_cnt <= sd_cnt + SD_W'(1);
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ats21_cmd_sched.sv
// Directed bench for ats21_cmd_sched with a queue-based scoreboard and a cycle monitor.
// Latency: expected done cycle per transaction is stored in each scoreboard entry.
// Backpressure: the bench drives ready one cycle after req unless ready is held low.
module tb_ats21_cmd_sched;

    logic        clk = 1'b0;
    logic        reset;
    logic        a_valid;
    logic [31:0] a_inst;
    logic        b_valid;
    logic [31:0] b_inst;
    logic        a_done;
    logic        b_done;
    logic        a_ack;
    logic        b_ack;
    logic        busy;
    logic        req;
    logic [15:0] ctrlA;
    logic [15:0] ctrlB;
    logic        ready;
    logic [1:0]  stat;

    typedef struct {
        int          lat;
        int          hi;
        logic [15:0] hia;
        logic [15:0] hib;
        logic [15:0] loa;
        logic [15:0] lob;
        logic [3:0]  dn;
    } exp_t;

    exp_t expq[$];
    exp_t cur;
    int   n_chk = 0;
    int   n_fail = 0;
    int   cyc = 0;
    bit   in_txn = 0;
    bit   auto_ready = 1;
    bit   rdy_pend = 0;

    always #5 clk = ~clk;

    ats21_cmd_sched #(
        .STAT_DELAY  (2),
        .RDY_TIMEOUT (15)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .a_valid (a_valid),
        .a_inst  (a_inst),
        .b_valid (b_valid),
        .b_inst  (b_inst),
        .a_done  (a_done),
        .b_done  (b_done),
        .a_ack   (a_ack),
        .b_ack   (b_ack),
        .busy    (busy),
        .req     (req),
        .ctrlA   (ctrlA),
        .ctrlB   (ctrlB),
        .ready   (ready),
        .stat    (stat)
    );

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] rq);
        n_chk++;
        if (act !== rq) begin
            n_fail++;
            $display("FAIL %s: actual=%0h required=%0h", nm, act, rq);
        end
    endtask

    // lat: cycles from the req cycle to the done cycle; hi: cycle of the high half
    function automatic exp_t mk(input int lat, input int hi,
                                input logic [15:0] hia, input logic [15:0] hib,
                                input logic [15:0] loa, input logic [15:0] lob,
                                input logic [3:0] dn);
        exp_t e;
        e.lat = lat; e.hi = hi;
        e.hia = hia; e.hib = hib; e.loa = loa; e.lob = lob;
        e.dn  = dn;
        return e;
    endfunction

    // ATS21 responder: ready high for the cycle after req
    always @(negedge clk) begin
        if (rdy_pend) begin
            ready = 1'b1;
            rdy_pend = 0;
        end else begin
            ready = 1'b0;
        end
        if (!reset && req && auto_ready) rdy_pend = 1;
    end

    // Monitor: tracks each transaction from its req and compares against the queue
    always @(negedge clk) begin
        logic [15:0] ea;
        logic [15:0] eb;
        if (reset) begin
            in_txn = 0;
        end else begin
            if (in_txn) cyc++;
            if (req) begin
                check("req_outside_txn", 64'(in_txn), 64'(0));
                check("req_expected", 64'(expq.size() != 0), 64'(1));
                if (expq.size() != 0) begin
                    cur = expq.pop_front();
                    in_txn = 1;
                    cyc = 0;
                end
            end
            check("busy", 64'(busy), 64'(in_txn));
            ea = '0;
            eb = '0;
            if (in_txn && cyc == cur.hi) begin
                ea = cur.hia; eb = cur.hib;
            end else if (in_txn && cyc == cur.hi + 1) begin
                ea = cur.loa; eb = cur.lob;
            end
            check("ctrl", 64'({ctrlA, ctrlB}), 64'({ea, eb}));
            if (a_done || b_done) begin
                check("done_in_txn", 64'(in_txn), 64'(1));
                if (in_txn) begin
                    check("done_latency", 64'(cyc), 64'(cur.lat));
                    check("done_ack", 64'({a_done, a_ack, b_done, b_ack}), 64'(cur.dn));
                    in_txn = 0;
                end
            end else if (in_txn && cyc >= cur.lat) begin
                n_chk++;
                n_fail++;
                $display("FAIL done_missing: actual=no done at cycle %0d required=done at cycle %0d", cyc, cur.lat);
                in_txn = 0;
            end
        end
    end

    task automatic wait_done(input string nm);
        bit got;
        got = 0;
        for (int k = 0; k < 60 && !got; k++) begin
            @(negedge clk);
            if (a_done || b_done) got = 1;
        end
        n_chk++;
        if (!got) begin
            n_fail++;
            $display("FAIL %s: actual=no done within 60 cycles required=done pulse", nm);
        end else begin
            if (a_done) a_valid = 1'b0;
            if (b_done) b_valid = 1'b0;
        end
    endtask

    task automatic check_all_zero(input string nm);
        check(nm, 64'({req, busy, a_done, b_done, a_ack, b_ack, ctrlA, ctrlB}), 64'(0));
    endtask

    initial begin
        bit seen;
        reset   = 1'b1;
        a_valid = 1'b0;
        b_valid = 1'b0;
        a_inst  = '0;
        b_inst  = '0;
        ready   = 1'b0;
        stat    = 2'b00;
        @(posedge clk);
        #1 check_all_zero("reset_outputs");
        repeat (2) @(negedge clk);
        reset = 1'b0;

        // Single client A; B slot stays NOP
        stat = 2'b01;
        expq.push_back(mk(6, 2, 16'h2200, 16'h0000, 16'h0005, 16'h0000, 4'b1100));
        a_inst = 32'h2200_0005; a_valid = 1'b1;
        wait_done("single_a");

        // Same-alarm conflict: A wins, B follows alone
        stat = 2'b11;
        expq.push_back(mk(6, 2, 16'hA080, 16'h0000, 16'h0010, 16'h0000, 4'b1100));
        expq.push_back(mk(6, 2, 16'h0000, 16'hC000, 16'h0000, 16'h0020, 4'b0011));
        a_inst = 32'hA080_0010; b_inst = 32'hC000_0020;
        a_valid = 1'b1; b_valid = 1'b1;
        wait_done("conflict1_first");
        wait_done("conflict1_second");

        // Repeat conflict: pointer now favours B
        expq.push_back(mk(6, 2, 16'h0000, 16'hC000, 16'h0000, 16'h0020, 4'b0011));
        expq.push_back(mk(6, 2, 16'hA080, 16'h0000, 16'h0010, 16'h0000, 4'b1100));
        a_valid = 1'b1; b_valid = 1'b1;
        wait_done("conflict2_first");
        wait_done("conflict2_second");

        // Different clocks share one transaction
        stat = 2'b11;
        expq.push_back(mk(6, 2, 16'h2200, 16'h2400, 16'h0001, 16'h0002, 4'b1111));
        a_inst = 32'h2200_0001; b_inst = 32'h2400_0002;
        a_valid = 1'b1; b_valid = 1'b1;
        wait_done("dual_clk");

        // Per-client status bits: A nack, B ack
        stat = 2'b10;
        expq.push_back(mk(6, 2, 16'h2200, 16'h2400, 16'h0001, 16'h0002, 4'b1011));
        a_valid = 1'b1; b_valid = 1'b1;
        wait_done("dual_stat10");

        // Different alarm indices do not conflict
        stat = 2'b11;
        expq.push_back(mk(6, 2, 16'hA080, 16'hC200, 16'h0010, 16'h0020, 4'b1111));
        a_inst = 32'hA080_0010; b_inst = 32'hC200_0020;
        a_valid = 1'b1; b_valid = 1'b1;
        wait_done("dual_alarm");

        // Two MODE writes conflict; pointer is back on A
        stat = 2'b01;
        expq.push_back(mk(6, 2, 16'h6000, 16'h0000, 16'h0001, 16'h0000, 4'b1100));
        expq.push_back(mk(6, 2, 16'h0000, 16'h6000, 16'h0000, 16'h0002, 4'b0010));
        a_inst = 32'h6000_0001; b_inst = 32'h6000_0002;
        a_valid = 1'b1; b_valid = 1'b1;
        wait_done("mode_first");
        wait_done("mode_second");

        // Ready never arrives: 15 wait cycles then done with Nack
        auto_ready = 0;
        stat = 2'b11;
        expq.push_back(mk(16, -10, 16'h0, 16'h0, 16'h0, 16'h0, 4'b1010));
        a_inst = 32'h2200_0001; b_inst = 32'h2400_0002;
        a_valid = 1'b1; b_valid = 1'b1;
        wait_done("ready_timeout");
        auto_ready = 1;

        // Reset during the low half aborts without a done pulse
        stat = 2'b01;
        expq.push_back(mk(6, 2, 16'h2200, 16'h0000, 16'h0005, 16'h0000, 4'b1100));
        a_inst = 32'h2200_0005; a_valid = 1'b1;
        seen = 0;
        for (int k = 0; k < 40 && !seen; k++) begin
            @(negedge clk);
            if (req) seen = 1;
        end
        check("abort_req_seen", 64'(seen), 64'(1));
        repeat (3) @(negedge clk);
        #2 reset = 1'b1;
        a_valid = 1'b0;
        #1 check_all_zero("reset_mid_lo");
        repeat (2) @(negedge clk);
        reset = 1'b0;
        repeat (4) @(negedge clk);

        // Resubmit a conflicting pair: priority restarted at A
        stat = 2'b11;
        expq.push_back(mk(6, 2, 16'h2200, 16'h0000, 16'h0003, 16'h0000, 4'b1100));
        expq.push_back(mk(6, 2, 16'h0000, 16'h4200, 16'h0000, 16'h0004, 4'b0011));
        a_inst = 32'h2200_0003; b_inst = 32'h4200_0004;
        a_valid = 1'b1; b_valid = 1'b1;
        wait_done("post_reset_first");
        wait_done("post_reset_second");

        repeat (4) @(negedge clk);
        check("scoreboard_drained", 64'({expq.size(), 1'(in_txn)}), 64'(0));
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: actual=still running required=finished");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/ats21_cmd_sched.md
ATS21_CMD_SCHED -- requirements
Module: ats21_cmd_sched

Interface
REQ-001 SHALL have parameter STAT_DELAY, default 2: cycles waited after the low half is driven before stat is sampled.
REQ-002 SHALL have parameter RDY_TIMEOUT, default 15: maximum cycles spent waiting for ready.
REQ-003 clk  in  1  single clock; all state updates on posedge clk.
REQ-004 reset  in  1  asynchronous, active-high reset.
REQ-005 a_valid  in  1  client A has an instruction pending; held until a_done.
REQ-006 a_inst  in  32  client A instruction; opcode in [31:29]; stable while a_valid.
REQ-007 b_valid  in  1  client B pending; same rules as a_valid.
REQ-008 b_inst  in  32  client B instruction.
REQ-009 a_done, b_done  out  1 each  one-cycle completion pulse per client.
REQ-010 a_ack, b_ack  out  1 each  result, valid only while the matching done is high; 1 = Ack.
REQ-011 busy  out  1  high whenever state is not IDLE.
REQ-012 req  out  1  ATS21 request strobe.
REQ-013 ctrlA, ctrlB  out  16 each  ATS21 instruction halves.
REQ-014 ready  in  1  ATS21 ready.
REQ-015 stat  in  2  ATS21 status; stat[0] = client A, stat[1] = client B.

Function
REQ-016 SHALL implement FSM states IDLE, REQ, WAIT_RDY, HI, LO, WAIT_STAT, RESP.
REQ-017 IDLE: when a_valid or b_valid is high, SHALL latch both instructions, resolve conflicts (REQ-019..021), and go to REQ next cycle.
REQ-018 Client with valid low at latch SHALL have 32'h0 (NOP) issued in its slot and SHALL receive no done pulse.
REQ-019 Conflict: both opcodes in {001,010} with equal [28:25]; or both in {101,110,111} with equal [28:24]; or both equal 011.
REQ-020 On conflict, only the priority client's instruction SHALL issue; the other slot SHALL carry NOP; the deferred client SHALL keep pending without a done pulse.
REQ-021 Priority pointer SHALL reset to A and SHALL toggle after every conflict is resolved.
REQ-022 REQ: req SHALL be 1 for exactly one cycle, then go to WAIT_RDY.
REQ-023 WAIT_RDY: on ready=1, go to HI; after RDY_TIMEOUT cycles without ready, go to RESP with both acks forced to 0.
REQ-024 HI: ctrlA/ctrlB SHALL equal latched [31:16] for one cycle; LO: ctrlA/ctrlB SHALL equal latched [15:0] for one cycle.
REQ-025 ctrlA/ctrlB SHALL be 0 in every state except HI and LO.
REQ-026 WAIT_STAT: SHALL count STAT_DELAY cycles, then sample stat into ack registers and go to RESP.
REQ-027 RESP: done pulses for issued clients only, with acks, for one cycle; then IDLE.
REQ-028 Issue-to-done latency without stalls: IDLE latch + 1 (REQ) + ready wait + 2 (HI, LO) + STAT_DELAY + 1 (RESP).
REQ-029 Deassertion of valid after latch SHALL be ignored until the next IDLE.
REQ-030 Timeout counter width SHALL be $clog2(RDY_TIMEOUT+1); STAT_DELAY counter SHALL saturate, not wrap.

Reset
REQ-031 Reset SHALL force IDLE, priority=A, and 0 on req, ctrlA, ctrlB, a_done, b_done, a_ack, b_ack and busy.
REQ-032 Reset mid-transaction SHALL abort it with no done pulses.
REQ-033 First sampling after reset release SHALL be in IDLE on the next posedge.

Structure
REQ-034 Package ats21_pkg SHALL hold the opcode enum (NOP, SET_CLK, EN_CLK, MODE, SET_ALM, SET_TMR, EN_ALM), the FSM state enum, and the 16-bit half width constant.
REQ-035 Conflict detection SHALL be a combinational sub-module ats21_conflict_chk (inputs: two instructions; output: conflict).

Verification
REQ-036 a_inst=32'h2200_0005 only, ready high 1 cycle after req, stat=01 -> ctrlA=2200 then 0005; a_done=1, a_ack=1; b_done=0; ctrlB=0,0.
REQ-037 a_inst=32'hA080_0010, b_inst=32'hC000_0020 (same alarm 0) -> first issue A with B slot NOP; B issues next transaction; next conflict favours B.
REQ-038 a_inst=32'h2200_0001, b_inst=32'h2400_0002 (clocks 1, 2) -> both issued in one transaction; stat=11 -> a_ack=b_ack=1.
REQ-039 ready held 0 -> after 15 WAIT_RDY cycles, done pulses with acks 0, back to IDLE.
REQ-040 reset asserted during LO -> all outputs 0 immediately; no done pulse; resubmission completes normally.
